gaussian_frame_ctrl: RTL and testbench

Frame-level sequencer for the 5x5 Gaussian smoothing stage of the raw ISP pipe. It tracks the raster position of the filter's output stream, latches the filter enable only at frame boundaries, and replaces filter output with aligned bypass data on the 2-pixel border and when filtering is disabled. It also reports frame completion and line-length errors. It sits directly after the Gaussian filter and before the downstream raw consumers.

---
 rtl/gaussian_frame_ctrl_if.sv | 21 ++
 rtl/gaussian_frame_ctrl.sv | 121 ++++++++++++
 tb/tb_gaussian_frame_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gaussian_frame_ctrl_if.sv
// Pixel stream bundle around the Gaussian frame sequencer: filtered, bypass and post-select streams.
// Valid-only (clken) signalling; no backpressure path exists on the raw pipe.
interface gaussian_frame_ctrl_if #(
  parameter int BITS = 8
);
  logic [BITS-1:0] flt_data;
  logic            flt_clken;
  logic [BITS-1:0] byp_data;
  logic [BITS-1:0] post_raw_data;
  logic            post_raw_clken;

  modport master (
    output flt_data, flt_clken, byp_data,
    input  post_raw_data, post_raw_clken
  );

  modport slave (
    input  flt_data, flt_clken, byp_data,
    output post_raw_data, post_raw_clken
  );
endinterface

// File: rtl/gaussian_frame_ctrl.sv
// Frame sequencer for the 5x5 Gaussian stage: raster tracking, border/enable select, frame_done.
// Latency 1 cycle; no backpressure (clken stream). Optional line check: GAUSS_FRAME_CTRL_LINE_CHECK_EN.
module gaussian_frame_ctrl #(
  parameter int WIDTH  = 1936,
  parameter int HEIGHT = 1096,
  parameter int BITS   = 8
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 per_frame_vsync,
  input  logic                 cfg_filter_en,
  gaussian_frame_ctrl_if.slave pix,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 line_err
);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE, GAP} state_t;

  localparam logic [11:0] X_HI  = 12'(WIDTH - 2);
  localparam logic [10:0] Y_HI  = 11'(HEIGHT - 2);
  localparam logic [10:0] Y_END = 11'(HEIGHT);
  localparam logic [11:0] X_MAX = 12'hFFF;
  localparam logic [10:0] Y_MAX = 11'h7FF;

  state_t      state;
  state_t      state_nxt;
  logic        vsync_q;
  logic        vsync_rise;
  logic        en_q;
  logic [11:0] x;
  logic [10:0] y;
  logic [10:0] y_inc;
  logic        line_end;
  logic        last_line;
  logic        border;
  logic        use_flt;

  assign vsync_rise = per_frame_vsync & ~vsync_q;
  assign line_end   = (state == ACTIVE) & ~pix.flt_clken;
  assign y_inc      = (y == Y_MAX) ? y : y + 11'd1;
  assign last_line  = (y_inc == Y_END);
  assign border     = (x < 12'd2) | (x >= X_HI) | (y < 11'd2) | (y >= Y_HI);
  // x/y always describe the pixel currently on flt_data; IDLE pixels are never filtered.
  assign use_flt    = en_q & ~border & (state != IDLE);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (vsync_rise) begin
      state_nxt = WAIT_LINE;
    end else begin
      case (state)
        IDLE:      state_nxt = IDLE;
        WAIT_LINE: if (pix.flt_clken) state_nxt = ACTIVE;
        ACTIVE:    if (!pix.flt_clken) state_nxt = last_line ? IDLE : GAP;
        GAP:       if (pix.flt_clken) state_nxt = ACTIVE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q            <= 1'b0;
      en_q               <= 1'b0;
      x                  <= '0;
      y                  <= '0;
      frame_done         <= 1'b0;
      pix.post_raw_data  <= '0;
      pix.post_raw_clken <= 1'b0;
    end else begin
      vsync_q            <= per_frame_vsync;
      pix.post_raw_clken <= pix.flt_clken;
      frame_done         <= ~vsync_rise & line_end & last_line;
      if (pix.flt_clken) begin
        pix.post_raw_data <= use_flt ? pix.flt_data : pix.byp_data;
      end
      if (vsync_rise) begin
        en_q <= cfg_filter_en;
        x    <= '0;
        y    <= '0;
      end else if (line_end) begin
        x <= '0;
        y <= y_inc;
      end else if (pix.flt_clken && state != IDLE) begin
        x <= (x == X_MAX) ? x : x + 12'd1;
      end
    end
  end

`ifdef GAUSS_FRAME_CTRL_LINE_CHECK_EN
  localparam logic [11:0] X_END = 12'(WIDTH);

  // At line end x equals the number of pixels seen; x==WIDTH mid-line is an overlong line.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      line_err <= 1'b0;
    end else if (vsync_rise) begin
      line_err <= 1'b0;
    end else if ((line_end && x != X_END) ||
                 (state == ACTIVE && pix.flt_clken && x == X_END)) begin
      line_err <= 1'b1;
    end
  end
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_gaussian_frame_ctrl.sv
// Directed bench for gaussian_frame_ctrl on an 8x6 frame with flt=0xAA, byp=0x55.
module tb_gaussian_frame_ctrl;

  localparam int W = 8;
  localparam int H = 6;

  logic pclk = 1'b0;
  logic rst_n;
  logic per_frame_vsync;
  logic cfg_filter_en;
  logic frame_done;
  logic busy;
  logic line_err;

  int n_cmp = 0;
  int n_bad = 0;
  int aa_cnt = 0;
  int done_cnt = 0;
  int mon_err = 0;
  bit mon_on = 1'b0;
  logic clken_d = 1'b0;

`ifdef GAUSS_FRAME_CTRL_LINE_CHECK_EN
  localparam int LE_EXP = 1;
`else
  localparam int LE_EXP = 0;
`endif

  gaussian_frame_ctrl_if #(.BITS(8)) pix_if ();

  gaussian_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .BITS(8)) dut (
    .pclk            (pclk),
    .rst_n           (rst_n),
    .per_frame_vsync (per_frame_vsync),
    .cfg_filter_en   (cfg_filter_en),
    .pix             (pix_if.slave),
    .frame_done      (frame_done),
    .busy            (busy),
    .line_err        (line_err)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) clken_d <= pix_if.flt_clken;

  always @(negedge pclk) begin
    if (frame_done) done_cnt++;
    if (mon_on && rst_n && (pix_if.post_raw_clken !== clken_d)) mon_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic vsync_pulse();
    per_frame_vsync = 1'b1;
    tick();
    tick();
    per_frame_vsync = 1'b0;
    tick();
  endtask

  task automatic send_line(input int len, input int yy, input bit en, output bit done);
    logic [7:0] exp;
    for (int xx = 0; xx < len; xx++) begin
      pix_if.flt_clken = 1'b1;
      pix_if.flt_data  = 8'hAA;
      pix_if.byp_data  = 8'h55;
      tick();
      exp = (en && xx >= 2 && xx < W - 2 && yy >= 2 && yy < H - 2) ? 8'hAA : 8'h55;
      chk($sformatf("pix_y%0d_x%0d", yy, xx), 32'(pix_if.post_raw_data), 32'(exp));
      if (pix_if.post_raw_data == 8'hAA) aa_cnt++;
    end
    pix_if.flt_clken = 1'b0;
    tick();
    done = frame_done;
    tick();
  endtask

  task automatic run_frame(input bit en, input int flip_at, input int first_line);
    bit done;
    for (int yy = first_line; yy < H; yy++) begin
      if (yy == flip_at) cfg_filter_en = 1'b1;
      send_line(W, yy, en, done);
      chk($sformatf("frame_done_y%0d", yy), 32'(done), (yy == H - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    int m0;
    bit done;

    rst_n            = 1'b0;
    per_frame_vsync  = 1'b0;
    cfg_filter_en    = 1'b0;
    pix_if.flt_clken = 1'b0;
    pix_if.flt_data  = 8'h00;
    pix_if.byp_data  = 8'h00;
    tick();
    tick();
    chk("rst_data",  32'(pix_if.post_raw_data), 32'd0);
    chk("rst_clken", 32'(pix_if.post_raw_clken), 32'd0);
    chk("rst_done",  32'(frame_done), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_lerr",  32'(line_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Filtered frame: only the inner 4x2 window carries 0xAA.
    cfg_filter_en = 1'b1;
    vsync_pulse();
    chk("busy_after_vsync", 32'(busy), 32'd1);
    aa_cnt = 0;
    d0 = done_cnt;
    run_frame(1'b1, -1, 0);
    chk("aa_count_en", 32'(aa_cnt), 32'd8);
    chk("done_pulses_f1", 32'(done_cnt - d0), 32'd1);
    chk("busy_after_frame", 32'(busy), 32'd0);

    // Back-to-back frames; enable raised mid-frame only applies on the next one.
    d0 = done_cnt;
    m0 = mon_err;
    mon_on = 1'b1;
    cfg_filter_en = 1'b0;
    vsync_pulse();
    aa_cnt = 0;
    run_frame(1'b0, 2, 0);
    chk("aa_count_dis", 32'(aa_cnt), 32'd0);
    vsync_pulse();
    aa_cnt = 0;
    run_frame(1'b1, -1, 0);
    chk("aa_count_next", 32'(aa_cnt), 32'd8);
    mon_on = 1'b0;
    chk("done_pulses_b2b", 32'(done_cnt - d0), 32'd2);
    chk("clken_delay", 32'(mon_err - m0), 32'd0);

    // Restart after line 3: no frame_done, next line is y=0.
    cfg_filter_en = 1'b1;
    vsync_pulse();
    d0 = done_cnt;
    for (int yy = 0; yy < 4; yy++) begin
      send_line(W, yy, 1'b1, done);
      chk($sformatf("restart_done_y%0d", yy), 32'(done), 32'd0);
    end
    vsync_pulse();
    chk("done_after_restart", 32'(done_cnt - d0), 32'd0);
    chk("busy_after_restart", 32'(busy), 32'd1);
    run_frame(1'b1, -1, 0);
    chk("done_restart_total", 32'(done_cnt - d0), 32'd1);

    // Line length checks.
    vsync_pulse();
    send_line(7, 0, 1'b1, done);
    chk("lerr_short", 32'(line_err), 32'(LE_EXP));
    vsync_pulse();
    chk("lerr_clear", 32'(line_err), 32'd0);
    send_line(W, 0, 1'b1, done);
    chk("lerr_good", 32'(line_err), 32'd0);
    send_line(9, 1, 1'b1, done);
    chk("lerr_long", 32'(line_err), 32'(LE_EXP));
    vsync_pulse();
    chk("lerr_clear2", 32'(line_err), 32'd0);

    // Reset at pixel (4,2), then IDLE pass-through.
    cfg_filter_en = 1'b1;
    vsync_pulse();
    send_line(W, 0, 1'b1, done);
    send_line(W, 1, 1'b1, done);
    for (int xx = 0; xx < 4; xx++) begin
      pix_if.flt_clken = 1'b1;
      pix_if.flt_data  = 8'hAA;
      pix_if.byp_data  = 8'h55;
      tick();
    end
    chk("pix_y2_x3", 32'(pix_if.post_raw_data), 32'hAA);
    rst_n = 1'b0;
    #1;
    chk("midrst_data",  32'(pix_if.post_raw_data), 32'd0);
    chk("midrst_clken", 32'(pix_if.post_raw_clken), 32'd0);
    chk("midrst_done",  32'(frame_done), 32'd0);
    chk("midrst_busy",  32'(busy), 32'd0);
    chk("midrst_lerr",  32'(line_err), 32'd0);
    pix_if.flt_clken = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int xx = 0; xx < 3; xx++) begin
      pix_if.flt_clken = 1'b1;
      pix_if.flt_data  = 8'hAA;
      pix_if.byp_data  = 8'h33 + 8'(xx);
      tick();
      chk($sformatf("idle_pass_x%0d", xx), 32'(pix_if.post_raw_data), 32'h33 + 32'(xx));
      chk($sformatf("idle_busy_x%0d", xx), 32'(busy), 32'd0);
    end
    pix_if.flt_clken = 1'b0;
    tick();
    chk("idle_clken_off", 32'(pix_if.post_raw_clken), 32'd0);
    chk("idle_data_hold", 32'(pix_if.post_raw_data), 32'h35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
